// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the MEM stage: access state, timeout/reset
// defaults, register-address width and the alignment helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int          TIMEOUT_CYC_DEF = 16;
    localparam logic [31:0] RESET_RDATA_DEF = 32'h0000_0000;
    localparam int          REG_AW          = 5;

    // A data access must be word aligned; any set low address bit is a fault.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads the stage results whenever the pipeline
// advances; while stalled it inserts a bubble by clearing the write-back
// controls and holding the data fields.
module mem_wb_reg
    import pipeline_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_stall,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_mem_data,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    output logic [31:0]       o_alu_result,
    output logic [31:0]       o_mem_data,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic              o_reg_write,
    output logic              o_mem_to_reg
);

    logic [31:0]       r_alu_result;
    logic [31:0]       r_mem_data;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_reg_write;
    logic              r_mem_to_reg;

    // Advance on unstalled edges, otherwise emit a bubble with held data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_alu_result <= 32'h0000_0000;
            r_mem_data   <= 32'h0000_0000;
            r_rd_addr    <= {REG_AW{1'b0}};
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!i_stall) begin
            r_alu_result <= i_alu_result;
            r_mem_data   <= i_mem_data;
            r_rd_addr    <= i_rd_addr;
            r_reg_write  <= i_reg_write;
            r_mem_to_reg <= i_mem_to_reg;
        end else begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end
    end

    assign o_alu_result = r_alu_result;
    assign o_mem_data   = r_mem_data;
    assign o_rd_addr    = r_rd_addr;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/gnt + rvalid memory
// handshake with a timeout, stalls upstream until each access finishes,
// registers MEM/WB and resolves branches combinationally.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] RESET_RDATA = RESET_RDATA_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [31:0]       RS2data_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic              Zero_i,
    input  logic              Branch_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stall_o,
    output logic              PCSrc_o,
    output logic [31:0]       ALUResult_o,
    output logic [31:0]       MemData_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              err_o
);

    // Counter holds up to TIMEOUT_CYC: a grant on the last REQ cycle enters
    // RESP one past the limit, which then aborts unless rvalid is present.
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    mem_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_memop;
    logic            w_is_load;
    logic            w_tmo;
    logic            w_stall;
    logic [31:0]     w_wb_mem_data;

    // A simultaneous read+write is handled as a store.
    assign w_memop   = MemRead_i | MemWrite_i;
    assign w_is_load = MemRead_i & ~MemWrite_i;
    assign w_tmo     = (r_cnt >= CW'(TIMEOUT_CYC - 1));

    // Upstream freeze: held while an access is pending, released in DONE.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = w_memop;
            REQ:     w_stall = 1'b1;
            RESP:    w_stall = 1'b1;
            DONE:    w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    // Load data reaches MEM/WB only when a load completes; otherwise zero.
    always_comb begin
        w_wb_mem_data = 32'h0000_0000;
        if ((r_state == DONE) && w_is_load) begin
            w_wb_mem_data = r_rdata;
        end else begin
            w_wb_mem_data = 32'h0000_0000;
        end
    end

    // Access state machine with request registers, timeout and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= CW'(0);
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= CW'(0);
                    if (w_memop) begin
                        if (is_misaligned(ALUResult_i)) begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                            r_rdata <= RESET_RDATA;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_we    <= MemWrite_i;
                            r_addr  <= ALUResult_i;
                            r_wdata <= RS2data_i;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_state <= DONE;
                            r_cnt   <= CW'(0);
                        end else begin
                            r_state <= RESP;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end else if (w_tmo) begin
                        r_req   <= 1'b0;
                        r_state <= DONE;
                        r_cnt   <= CW'(0);
                        r_err   <= 1'b1;
                        r_rdata <= RESET_RDATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        r_state <= DONE;
                        r_cnt   <= CW'(0);
                        r_rdata <= mem_rdata_i;
                    end else if (w_tmo) begin
                        r_state <= DONE;
                        r_cnt   <= CW'(0);
                        r_err   <= 1'b1;
                        r_rdata <= RESET_RDATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= CW'(0);
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= CW'(0);
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_stall      (w_stall),
        .i_alu_result (ALUResult_i),
        .i_mem_data   (w_wb_mem_data),
        .i_rd_addr    (RDaddr_i),
        .i_reg_write  (RegWrite_i),
        .i_mem_to_reg (MemtoReg_i),
        .o_alu_result (ALUResult_o),
        .o_mem_data   (MemData_o),
        .o_rd_addr    (RDaddr_o),
        .o_reg_write  (RegWrite_o),
        .o_mem_to_reg (MemtoReg_o)
    );

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign err_o       = r_err;
    assign stall_o     = w_stall;
    assign PCSrc_o     = Branch_i & Zero_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized instruction
// streams against a transaction-level latency/result model, with a bench-side
// memory slave whose grant/response delays are chosen per instruction.
module tb_mem_access_stage;

    localparam int          T  = 4;
    localparam logic [31:0] RR = 32'h0000_0000;
    localparam int          NEVER = 99;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] ALUResult_i, RS2data_i;
    logic [4:0]  RDaddr_i;
    logic        Zero_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, PCSrc_o;
    logic [31:0] ALUResult_o, MemData_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o, MemtoReg_o, err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_err = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYC(T), .RESET_RDATA(RR)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i),
        .Zero_i(Zero_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .PCSrc_o(PCSrc_o),
        .ALUResult_o(ALUResult_o), .MemData_o(MemData_o), .RDaddr_o(RDaddr_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .err_o(err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ALUResult_i = 32'h0; RS2data_i = 32'h0; RDaddr_i = 5'd0;
        Zero_i = 1'b0; Branch_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        MemtoReg_i = 1'b0; RegWrite_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. g = grant wait in request
    // cycles (NEVER = no grant), v = extra cycles after the grant before rvalid.
    task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rd, input logic rw, input logic m2r,
                             input int g, input int v, input logic [31:0] rdata);
        int exp_stall, exp_reqc, stall_cnt, reqc, since, done_at;
        logic [31:0] exp_md;
        logic fault, st, rq, gv, finished, bubble_seen;
        logic b, z;
        // Reference: latency and result from access-level timing rules.
        exp_md = 32'h0; exp_reqc = 0; fault = 1'b0; exp_stall = 0;
        if (kind == 0) begin
            exp_stall = 0;
        end else if (addr[1:0] != 2'b00) begin
            exp_stall = 1; fault = 1'b1; exp_md = (kind == 1) ? RR : 32'h0;
        end else if (g >= T) begin
            exp_stall = 1 + T; exp_reqc = T; fault = 1'b1; exp_md = (kind == 1) ? RR : 32'h0;
        end else if (kind == 2) begin
            exp_stall = 2 + g; exp_reqc = g + 1;
        end else begin
            exp_reqc = g + 1;
            done_at  = g + 1 + v;
            if (done_at <= T - 1) begin
                exp_stall = 2 + done_at; exp_md = rdata;
            end else begin
                exp_stall = 1 + T; fault = 1'b1; exp_md = RR;
            end
        end
        if (fault) model_err = 1'b1;

        b = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
        ALUResult_i = addr; RS2data_i = wd; RDaddr_i = rd;
        MemRead_i = (kind == 1); MemWrite_i = (kind == 2);
        RegWrite_i = rw; MemtoReg_i = m2r; Branch_i = b; Zero_i = z;
        #1;
        check_eq("pcsrc", {31'h0, PCSrc_o}, {31'h0, b & z});

        stall_cnt = 0; reqc = 0; since = 0; finished = 1'b0; bubble_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            rq = mem_req_o;
            gv = rq && (reqc == g);
            mem_gnt_i    = gv;
            mem_rvalid_i = (kind == 1) && (since > 0) && (since == v + 1);
            mem_rdata_i  = mem_rvalid_i ? rdata : $urandom();
            if (rq) begin
                check_eq("req_addr",  mem_addr_o, addr);
                check_eq("req_wdata", mem_wdata_o, wd);
                check_eq("req_we",    {31'h0, mem_we_o}, {31'h0, kind == 2});
            end
            st = stall_o;
            @(posedge clk); #1;
            if (rq) reqc++;
            if (gv) since = 1; else if (since > 0) since++;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (st) begin
                stall_cnt++;
                if (!bubble_seen) begin
                    check_eq("bubble_regwrite", {31'h0, RegWrite_o}, 32'h0);
                    bubble_seen = 1'b1;
                end
            end else begin
                finished = 1'b1;
            end
        end
        check_eq("completed", {31'h0, finished}, 32'h1);
        check_eq("stall_cycles", stall_cnt, exp_stall);
        check_eq("req_cycles",   reqc, exp_reqc);
        check_eq("wb_alu",       ALUResult_o, addr);
        check_eq("wb_rd",        {27'h0, RDaddr_o}, {27'h0, rd});
        check_eq("wb_regwrite",  {31'h0, RegWrite_o}, {31'h0, rw});
        check_eq("wb_memtoreg",  {31'h0, MemtoReg_o}, {31'h0, m2r});
        check_eq("wb_memdata",   MemData_o, exp_md);
        check_eq("err",          {31'h0, err_o}, {31'h0, model_err});
    endtask

    initial begin
        int kind, g, v;
        logic [31:0] addr;
        rst_i = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",   {31'h0, mem_req_o}, 32'h0);
        check_eq("rst_err",   {31'h0, err_o}, 32'h0);
        check_eq("rst_alu",   ALUResult_o, 32'h0);
        check_eq("rst_rw",    {31'h0, RegWrite_o}, 32'h0);
        rst_i = 1'b0;

        // ALU-only stream.
        run_instr(0, 32'h0000_1111, 32'h0, 5'd3, 1'b1, 1'b0, 0, 0, 32'h0);
        run_instr(0, 32'h0000_2222, 32'h0, 5'd7, 1'b1, 1'b0, 0, 0, 32'h0);
        run_instr(0, 32'h0000_3333, 32'h0, 5'd31, 1'b1, 1'b0, 0, 0, 32'h0);
        // Store with grant on the second request cycle.
        run_instr(2, 32'h0000_0040, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1, 0, 32'h0);
        // Load with one extra response cycle.
        run_instr(1, 32'h0000_0080, 32'h0, 5'd9, 1'b1, 1'b1, 0, 1, 32'h1234_5678);
        // Misaligned load.
        run_instr(1, 32'h0000_0082, 32'h0, 5'd10, 1'b1, 1'b1, 0, 0, 32'h5555_5555);
        // Request timeout, then a normal load with the error still set.
        run_instr(1, 32'h0000_00C0, 32'h0, 5'd11, 1'b1, 1'b1, NEVER, 0, 32'h6666_6666);
        run_instr(1, 32'h0000_00C4, 32'h0, 5'd12, 1'b1, 1'b1, 0, 0, 32'hA5A5_0001);

        // Reset while in RESP, stray rvalid afterwards must be ignored.
        ALUResult_i = 32'h0000_0100; MemRead_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd4;
        @(posedge clk); #1;
        check_eq("rst_pre_req", {31'h0, mem_req_o}, 32'h1);
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_err = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        check_eq("post_rst_req",   {31'h0, mem_req_o}, 32'h0);
        check_eq("post_rst_stall", {31'h0, stall_o}, 32'h0);
        check_eq("post_rst_data",  MemData_o, 32'h0);
        check_eq("post_rst_rw",    {31'h0, RegWrite_o}, 32'h0);
        check_eq("post_rst_err",   {31'h0, err_o}, 32'h0);
        run_instr(1, 32'h0000_0200, 32'h0, 5'd5, 1'b1, 1'b1, 1, 0, 32'h0BAD_F00D);

        // Randomized instruction mix and memory latencies.
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            g = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, T - 1);
            if (kind == 1 && g == T - 1) g = T - 2;
            v = $urandom_range(0, 3);
            run_instr(kind, addr, $urandom(), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g, v, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
